// File: rtl/core_lsu.sv
// core_lsu: load/store unit bridging a pipeline request to a single-beat memory port.
// Parameters: ADDR_W address width (>=3), TIMEOUT abort limit in REQ+WAIT cycles (0 = never).
// Pipeline side: lsu_req_i/lsu_ready_o accept a request; lsu_valid_o strobes completion
//   with lsu_rdata_o (extended load data), lsu_err_o and lsu_err_code_o
//   (00 ok, 01 misaligned, 10 timeout, 11 illegal size).
// Memory side: mem_req_o/mem_gnt_i handshake, mem_addr_o word-aligned, mem_be_o lanes,
//   mem_wdata_o lane-replicated, mem_rvalid_i/mem_rdata_i response.
module core_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_unsigned_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_ready_o,
    output logic              lsu_valid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic [1:0]        lsu_err_code_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic [1:0] size, code;
    logic we, uns;
    logic [31:0] wdata, rdata_q, cnt;
    logic mis, tmo, act;
    logic [31:0] sh, ext;
    assign mis = (lsu_size_i == 2'b01 && lsu_addr_i[0]) || (lsu_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);
    assign tmo = TIMEOUT != 0 && cnt + 32'd1 == 32'(TIMEOUT);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            size    <= '0;
            code    <= '0;
            we      <= 1'b0;
            uns     <= 1'b0;
            wdata   <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (lsu_req_i) begin
                    addr  <= lsu_addr_i;
                    size  <= lsu_size_i;
                    we    <= lsu_we_i;
                    uns   <= lsu_unsigned_i;
                    wdata <= lsu_wdata_i;
                    cnt   <= '0;
                    code  <= lsu_size_i == 2'b11 ? 2'b11 : mis ? 2'b01 : 2'b00;
                    state <= (lsu_size_i == 2'b11 || mis) ? DONE : REQ;
                end
                REQ: begin
                    cnt <= cnt + 32'd1;
                    if (tmo) begin
                        code  <= 2'b10;
                        state <= DONE;
                    end else if (mem_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (tmo) begin
                        code  <= 2'b10;
                        state <= DONE;
                    end else if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        state   <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    // memory-side outputs are only driven while a request is outstanding so they read 0 elsewhere
    assign act         = state == REQ;
    assign mem_req_o   = act;
    assign mem_addr_o  = act ? {addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we_o    = act && we;
    assign mem_be_o    = !act ? 4'b0000 : size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign mem_wdata_o = !act ? 32'd0 : size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    assign sh  = rdata_q >> {addr[1:0], 3'b000};
    assign ext = size == 2'b00 ? {{24{~uns & sh[7]}}, sh[7:0]} : size == 2'b01 ? {{16{~uns & sh[15]}}, sh[15:0]} : rdata_q;
    assign lsu_ready_o    = state == IDLE;
    assign lsu_valid_o    = state == DONE;
    assign lsu_err_code_o = lsu_valid_o ? code : 2'b00;
    assign lsu_err_o      = lsu_valid_o && code != 2'b00;
    assign lsu_rdata_o    = (lsu_valid_o && !we && code == 2'b00) ? ext : 32'd0;
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed-vector bench for core_lsu with a short timeout.
module tb_core_lsu;
    logic clk = 1'b0, rst = 1'b1;
    logic req = 1'b0, we = 1'b0, uns = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [1:0] size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, mrdata = '0;
    logic ready, valid, err, mreq, mwe;
    logic [1:0] code;
    logic [3:0] be;
    logic [31:0] rdata, maddr, mwdata;
    int vecs = 0, errs = 0;

    core_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_unsigned_i(uns), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_ready_o(ready),
        .lsu_valid_o(valid), .lsu_rdata_o(rdata), .lsu_err_o(err), .lsu_err_code_o(code),
        .mem_req_o(mreq), .mem_gnt_i(gnt), .mem_addr_o(maddr), .mem_we_o(mwe), .mem_be_o(be),
        .mem_wdata_o(mwdata), .mem_rvalid_i(rvalid), .mem_rdata_i(mrdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        chk("accept_ready", 32'(ready), 1);
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_mreq", 32'(mreq), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", 32'(be), 0);
        rst = 1'b0;
        @(negedge clk);

        // signed byte load at lane 3
        issue(1'b0, 2'b00, 1'b0, 32'h1003, 0);
        chk("sb_mreq", 32'(mreq), 1);
        chk("sb_be", 32'(be), 32'b1000);
        chk("sb_addr", maddr, 32'h1000);
        chk("sb_we", 32'(mwe), 0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("sb_mreq_wait", 32'(mreq), 0);
        chk("sb_valid_early", 32'(valid), 0);
        rvalid = 1'b1; mrdata = 32'h80AABBCC;
        @(negedge clk);
        rvalid = 1'b0;
        chk("sb_valid", 32'(valid), 1);
        chk("sb_rdata", rdata, 32'hFFFFFF80);
        chk("sb_err", 32'(err), 0);
        @(negedge clk);
        chk("sb_valid_off", 32'(valid), 0);
        chk("sb_ready", 32'(ready), 1);

        // half store at upper half, grant delayed one cycle
        issue(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF);
        chk("sh_be", 32'(be), 32'b1100);
        chk("sh_wdata", mwdata, 32'hBEEFBEEF);
        chk("sh_addr", maddr, 32'h2000);
        chk("sh_we", 32'(mwe), 1);
        @(negedge clk);
        chk("sh_hold_req", 32'(mreq), 1);
        chk("sh_hold_be", 32'(be), 32'b1100);
        chk("sh_hold_wdata", mwdata, 32'hBEEFBEEF);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rvalid = 1'b1; mrdata = 32'hDEADBEEF;
        @(negedge clk);
        rvalid = 1'b0;
        chk("sh_valid", 32'(valid), 1);
        chk("sh_rdata_zero", rdata, 0);
        @(negedge clk);

        // misaligned word, misaligned half, illegal size
        issue(1'b0, 2'b10, 1'b0, 32'h0001, 0);
        chk("mw_valid", 32'(valid), 1);
        chk("mw_code", 32'(code), 1);
        chk("mw_err", 32'(err), 1);
        chk("mw_mreq", 32'(mreq), 0);
        chk("mw_rdata", rdata, 0);
        @(negedge clk);
        chk("mw_ready", 32'(ready), 1);
        issue(1'b1, 2'b01, 1'b0, 32'h0003, 0);
        chk("mh_code", 32'(code), 1);
        chk("mh_mreq", 32'(mreq), 0);
        @(negedge clk);
        issue(1'b0, 2'b11, 1'b0, 32'h0000, 0);
        chk("il_valid", 32'(valid), 1);
        chk("il_code", 32'(code), 3);
        chk("il_mreq", 32'(mreq), 0);
        @(negedge clk);

        // timeout with grant arriving only in the timeout cycle
        issue(1'b0, 2'b10, 1'b0, 32'h0040, 0);
        for (int i = 0; i < 4; i++) begin
            chk("to_mreq", 32'(mreq), 1);
            chk("to_valid_early", 32'(valid), 0);
            if (i == 3) gnt = 1'b1;
            @(negedge clk);
        end
        gnt = 1'b0;
        chk("to_valid", 32'(valid), 1);
        chk("to_code", 32'(code), 2);
        chk("to_err", 32'(err), 1);
        chk("to_mreq_done", 32'(mreq), 0);
        @(negedge clk);
        chk("to_ready", 32'(ready), 1);
        chk("to_valid_off", 32'(valid), 0);

        // unsigned half load, rvalid ignored while still in REQ
        issue(1'b0, 2'b01, 1'b1, 32'h0010, 0);
        rvalid = 1'b1; mrdata = 32'h55555555;
        @(negedge clk);
        rvalid = 1'b0;
        chk("uh_still_req", 32'(mreq), 1);
        chk("uh_be", 32'(be), 32'b0011);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rvalid = 1'b1; mrdata = 32'h1234F00D;
        @(negedge clk);
        rvalid = 1'b0;
        chk("uh_rdata", rdata, 32'h0000F00D);
        @(negedge clk);

        // signed half from upper lane and word pass-through
        issue(1'b0, 2'b01, 1'b0, 32'h0012, 0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; mrdata = 32'h8001F00D;
        @(negedge clk);
        rvalid = 1'b0;
        chk("shl_rdata", rdata, 32'hFFFF8001);
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h0024, 0);
        chk("w_be", 32'(be), 32'hF);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; mrdata = 32'h8765ABCD;
        @(negedge clk);
        rvalid = 1'b0;
        chk("w_rdata", rdata, 32'h8765ABCD);
        @(negedge clk);

        // reset while waiting, then a stale response
        issue(1'b0, 2'b10, 1'b0, 32'h0080, 0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rw_ready", 32'(ready), 1);
        chk("rw_mreq", 32'(mreq), 0);
        chk("rw_addr", maddr, 0);
        @(negedge clk);
        rst = 1'b0;
        rvalid = 1'b1; mrdata = 32'hFFFFFFFF;
        @(negedge clk);
        rvalid = 1'b0;
        chk("rw_valid", 32'(valid), 0);
        chk("rw_ready_after", 32'(ready), 1);
        @(negedge clk);
        chk("rw_valid2", 32'(valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width in bits (at least 3).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in REQ plus WAIT before abort; 0 disables the timeout.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 lsu_req_i  in  1  pipeline load/store request.
REQ-006 lsu_we_i  in  1  1=store, 0=load.
REQ-007 lsu_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 lsu_unsigned_i  in  1  zero-extend load result when 1.
REQ-009 lsu_addr_i  in  ADDR_W  byte address.
REQ-010 lsu_wdata_i  in  32  store data, right-aligned.
REQ-011 lsu_ready_o  out  1  block accepts a request this cycle.
REQ-012 lsu_valid_o  out  1  one-cycle completion strobe.
REQ-013 lsu_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-014 lsu_err_o  out  1  completion carries an error.
REQ-015 lsu_err_code_o  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size.
REQ-016 mem_req_o  out  1  memory request.
REQ-017 mem_gnt_i  in  1  memory grant.
REQ-018 mem_addr_o  out  ADDR_W  word-aligned address: lsu_addr_i with bits [1:0] forced to 00.
REQ-019 mem_we_o  out  1  write enable.
REQ-020 mem_be_o  out  4  byte enables.
REQ-021 mem_wdata_o  out  32  lane-replicated store data.
REQ-022 mem_rvalid_i  in  1  response valid, for both loads and stores.
REQ-023 mem_rdata_i  in  32  read data word.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, WAIT and DONE, and lsu_ready_o SHALL equal 1 only in IDLE.
REQ-025 The block SHALL accept a request when lsu_req_i=1 and lsu_ready_o=1, and SHALL register the address, size, we, unsigned and wdata fields at acceptance.
REQ-026 On acceptance with lsu_size_i=11, the FSM SHALL go to DONE with code 11 and SHALL NOT assert mem_req_o.
REQ-027 On acceptance with half and addr[0]=1, or word and addr[1:0]!=00, the FSM SHALL go to DONE with code 01 and SHALL NOT assert mem_req_o.
REQ-028 On any other acceptance, the FSM SHALL go to REQ.
REQ-029 In REQ, mem_req_o SHALL be 1, and mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o SHALL be held stable until the grant.
REQ-030 In REQ with mem_gnt_i=1, the FSM SHALL go to WAIT, and mem_req_o SHALL be 0 from the next cycle.
REQ-031 In WAIT, mem_req_o SHALL be 0, and mem_rvalid_i=1 SHALL move the FSM to DONE with code 00.
REQ-032 mem_rvalid_i SHALL be ignored in IDLE, REQ and DONE.
REQ-033 For bytes, the block SHALL drive mem_be_o = 0001 shifted left by addr[1:0], and mem_wdata_o = four copies of wdata[7:0].
REQ-034 For halves, the block SHALL drive mem_be_o = 0011 shifted left by addr[1:0], and mem_wdata_o = two copies of wdata[15:0].
REQ-035 For words, the block SHALL drive mem_be_o = 1111 and mem_wdata_o = wdata.
REQ-036 For loads, lsu_rdata_o SHALL be the byte or half selected by the registered addr[1:0], sign-extended, or zero-extended when unsigned; words SHALL pass through unchanged.
REQ-037 The block SHALL register mem_rdata_i on the WAIT-to-DONE transition.
REQ-038 The timeout counter SHALL clear on acceptance and increment each cycle in REQ or WAIT.
REQ-039 When TIMEOUT is nonzero and the counter reaches TIMEOUT, the FSM SHALL go to DONE with code 10 and mem_req_o=0, taking precedence over a same-cycle mem_gnt_i or mem_rvalid_i.
REQ-040 In DONE, lsu_valid_o SHALL be 1 for exactly one cycle with lsu_err_o = (code!=00), and the FSM SHALL then go to IDLE.
REQ-041 Latency from acceptance SHALL be 1 cycle for errors detected at acceptance, and a minimum of 3 cycles for memory accesses (grant and rvalid each in their first possible cycle).
REQ-042 Accepted requests SHALL be spaced at least 2 cycles apart after a completion.

Reset
REQ-043 While rst_i=1, including mid-transaction, the FSM SHALL be in IDLE and the timeout counter SHALL be 0.
REQ-044 While rst_i=1, all outputs SHALL be 0 except lsu_ready_o=1.
REQ-045 A response arriving after reset SHALL be ignored, consistent with REQ-032.

Verification
REQ-046 Signed byte load: addr=0x1003, mem_rdata=0x80AABBCC -> lsu_rdata_o=0xFFFFFF80, mem_be_o=1000, and lsu_valid_o 3 cycles after acceptance with immediate grant and rvalid.
REQ-047 Half store: addr=0x2002, wdata=0x0000BEEF -> mem_be_o=1100, mem_wdata_o=0xBEEFBEEF, mem_addr_o=0x2000, mem_we_o=1.
REQ-048 Misaligned word load: addr=0x0001 -> no mem_req_o, lsu_valid_o next cycle, lsu_err_code_o=01; lsu_size_i=11 -> code 11.
REQ-049 Timeout: TIMEOUT=4 with mem_gnt_i held 0 -> mem_req_o high 4 cycles, then lsu_valid_o with code 10; grant in the timeout cycle is ignored.
REQ-050 Reset in WAIT, then mem_rvalid_i pulse -> lsu_valid_o stays 0 and lsu_ready_o=1.
REQ-051 Unsigned half load: addr=0x10, rdata=0x1234F00D -> lsu_rdata_o=0x0000F00D.
